// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers bus writes and launches them one at a
// time over the tx_data/tx_start/tx_busy handshake, with occupancy and sticky error status.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              overflow_clr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_err,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      TIMER_LAST = 8'(BUSY_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d, tx_err_q, tx_err_d;
  logic [7:0]          data_q, data_d;
  logic                start_q, start_d;
  logic [7:0]          mem [DEPTH];

  logic push, pop, overflow_set, timeout;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // A write during flush is silently discarded and never counts as an overflow.
  assign push         = wr_en && !full && !flush;
  assign overflow_set = wr_en && full && !flush;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && !uart_tx_busy && !flush) begin
          state_d = WAIT_BUSY;
          timer_d = '0;
        end
      end
      WAIT_BUSY: begin
        if (uart_tx_busy)               state_d = WAIT_DONE;
        else if (timer_q == TIMER_LAST) state_d = IDLE;
        else                            timer_d = timer_q + 8'd1;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pop     = (state_q == IDLE) && !empty && !uart_tx_busy && !flush;
    timeout = (state_q == WAIT_BUSY) && !uart_tx_busy && (timer_q == TIMER_LAST);
    start_d = pop;
    data_d  = pop ? mem[rd_ptr_q] : data_q;
  end

  // ---------------- Pointers, occupancy, sticky flags ----------------
  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    // A set event in the same cycle as a clear wins.
    overflow_d = overflow_set | (overflow_q & ~overflow_clr);
    tx_err_d   = timeout      | (tx_err_q   & ~overflow_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
      data_q     <= 8'h00;
      start_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
      data_q     <= data_d;
      start_q    <= start_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign count         = count_q;
  assign overflow      = overflow_q;
  assign tx_err        = tx_err_q;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = start_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small UART busy model plus one task per scenario,
// each comparing DUT outputs against hand-computed values on the falling edge.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, wr_en, flush, overflow_clr;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_err, uart_tx_start, uart_tx_busy;
  logic [4:0] count;
  logic [7:0] uart_tx_data;

  int checks   = 0;
  int failures = 0;

  typedef enum int {BUSY_AUTO, BUSY_HI, BUSY_LO} busy_mode_e;
  busy_mode_e mode = BUSY_LO;
  logic       auto_busy = 1'b0;
  int         delay = 0;
  int         hold  = 0;

  logic [7:0] sent_q[$];
  bit         prev_start   = 1'b0;
  bit         double_start = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .BUSY_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .overflow_clr (overflow_clr),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_err       (tx_err),
    .uart_tx_data (uart_tx_data),
    .uart_tx_start(uart_tx_start),
    .uart_tx_busy (uart_tx_busy)
  );

  always #5 clk = ~clk;

  assign uart_tx_busy = (mode == BUSY_HI) ? 1'b1 : (mode == BUSY_LO) ? 1'b0 : auto_busy;

  // UART model: busy rises one cycle after the start pulse and stays high for 10 cycles.
  always @(negedge clk) begin
    if (mode != BUSY_AUTO) begin
      delay = 0; hold = 0; auto_busy = 1'b0;
    end else if (uart_tx_start === 1'b1) begin
      delay = 1;
    end else if (delay > 0) begin
      delay = 0; auto_busy = 1'b1; hold = 10;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) auto_busy = 1'b0;
    end
  end

  // Launch monitor: logs every byte presented with a start pulse.
  always @(negedge clk) begin
    if (uart_tx_start === 1'b1) begin
      sent_q.push_back(uart_tx_data);
      if (prev_start) double_start = 1'b1;
    end
    prev_start = (uart_tx_start === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk); wr_en = 1'b1; wr_data = b;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic push_when_room(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    while (full === 1'b1 && k < 500) begin @(negedge clk); k++; end
    wr_en = 1'b1; wr_data = b;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget, input string name);
    int k = 0;
    while (sent_q.size() < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (sent_q.size() < n) begin
      failures++;
      $display("FAIL %s: launched %0d bytes, required %0d", name, sent_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    checks += 7;
    if (empty !== 1'b1)         begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
    if (full !== 1'b0)          begin failures++; $display("FAIL reset_full: got %b want 0", full); end
    if (count !== 5'd0)         begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
    if (uart_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", uart_tx_start); end
    if (uart_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", uart_tx_data); end
    if (overflow !== 1'b0)      begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (tx_err !== 1'b0)        begin failures++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
  endtask

  task automatic test_single_byte();
    int base = sent_q.size();
    mode = BUSY_AUTO;
    write_byte(8'hA5);
    checks++;
    if (count !== 5'd1) begin failures++; $display("FAIL single_count_after_write: got %0d want 1", count); end
    @(negedge clk);
    checks += 3;
    if (uart_tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", uart_tx_start); end
    if (uart_tx_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", uart_tx_data); end
    if (count !== 5'd0)         begin failures++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
    repeat (20) @(negedge clk);
    checks += 2;
    if (sent_q.size() != base + 1) begin failures++; $display("FAIL single_launch_count: got %0d want %0d", sent_q.size(), base + 1); end
    if (uart_tx_data !== 8'hA5)    begin failures++; $display("FAIL single_data_hold: got %h want a5", uart_tx_data); end
  endtask

  task automatic test_fill_overflow();
    int base = sent_q.size();
    @(negedge clk); mode = BUSY_HI;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        checks += 3;
        if (full !== 1'b1)      begin failures++; $display("FAIL fill_full: got %b want 1", full); end
        if (count !== 5'd16)    begin failures++; $display("FAIL fill_count: got %0d want 16", count); end
        if (overflow !== 1'b0)  begin failures++; $display("FAIL fill_overflow_early: got %b want 0", overflow); end
      end
      wr_en = 1'b1; wr_data = 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    checks += 2;
    if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow_set: got %b want 1", overflow); end
    if (count !== 5'd16)   begin failures++; $display("FAIL fill_count_after_drop: got %0d want 16", count); end
    mode = BUSY_AUTO;
    wait_sent(base + 16, 500, "fill_drain");
    repeat (20) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (base + i >= sent_q.size() || sent_q[base + i] !== 8'(i)) begin
        failures++; $display("FAIL fill_order[%0d]: got %h want %h", i,
                             (base + i < sent_q.size()) ? sent_q[base + i] : 8'hxx, 8'(i));
      end
    end
    checks += 3;
    if (sent_q.size() != base + 16) begin failures++; $display("FAIL fill_no_extra: got %0d want %0d", sent_q.size(), base + 16); end
    if (empty !== 1'b1)    begin failures++; $display("FAIL fill_empty_after: got %b want 1", empty); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow_sticky: got %b want 1", overflow); end
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow_clr: got %b want 0", overflow); end
  endtask

  task automatic test_concurrent_wrap();
    int base = sent_q.size();
    @(negedge clk); mode = BUSY_HI;
    write_byte(8'h40); write_byte(8'h41); write_byte(8'h42);
    checks++;
    if (count !== 5'd3) begin failures++; $display("FAIL conc_count_pre: got %0d want 3", count); end
    mode = BUSY_AUTO; wr_en = 1'b1; wr_data = 8'h43;
    @(negedge clk); wr_en = 1'b0;
    checks += 3;
    if (count !== 5'd3)         begin failures++; $display("FAIL conc_count_same: got %0d want 3", count); end
    if (uart_tx_start !== 1'b1) begin failures++; $display("FAIL conc_start: got %b want 1", uart_tx_start); end
    if (uart_tx_data !== 8'h40) begin failures++; $display("FAIL conc_data: got %h want 40", uart_tx_data); end
    for (int i = 4; i < 20; i++) push_when_room(8'h40 + 8'(i));
    wait_sent(base + 20, 800, "wrap_drain");
    repeat (20) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (base + i >= sent_q.size() || sent_q[base + i] !== 8'h40 + 8'(i)) begin
        failures++; $display("FAIL wrap_order[%0d]: got %h want %h", i,
                             (base + i < sent_q.size()) ? sent_q[base + i] : 8'hxx, 8'h40 + 8'(i));
      end
    end
    checks += 2;
    if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
    if (empty !== 1'b1)    begin failures++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_flush();
    int base = sent_q.size();
    int k = 0;
    mode = BUSY_AUTO;
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i));
    while (!(sent_q.size() >= base + 2 && uart_tx_busy === 1'b1) && k < 300) begin
      @(negedge clk); k++;
    end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk); flush = 1'b0; wr_en = 1'b0;
    checks += 3;
    if (count !== 5'd0)    begin failures++; $display("FAIL flush_count: got %0d want 0", count); end
    if (empty !== 1'b1)    begin failures++; $display("FAIL flush_empty: got %b want 1", empty); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow: got %b want 0", overflow); end
    repeat (60) @(negedge clk);
    checks += 3;
    if (sent_q.size() != base + 2) begin failures++; $display("FAIL flush_launches: got %0d want %0d", sent_q.size(), base + 2); end
    if (sent_q.size() >= base + 2 && sent_q[base + 1] !== 8'h61) begin
      failures++; $display("FAIL flush_second_byte: got %h want 61", sent_q[base + 1]);
    end
    if (count !== 5'd0) begin failures++; $display("FAIL flush_count_late: got %0d want 0", count); end
  endtask

  task automatic test_timeout();
    @(negedge clk); mode = BUSY_LO;
    checks++;
    if (tx_err !== 1'b0) begin failures++; $display("FAIL to_err_pre: got %b want 0", tx_err); end
    wr_en = 1'b1; wr_data = 8'h81;
    @(negedge clk); wr_data = 8'h82;
    @(negedge clk); wr_en = 1'b0;
    checks += 2;
    if (uart_tx_start !== 1'b1) begin failures++; $display("FAIL to_start1: got %b want 1", uart_tx_start); end
    if (uart_tx_data !== 8'h81) begin failures++; $display("FAIL to_data1: got %h want 81", uart_tx_data); end
    repeat (3) @(negedge clk);
    checks++;
    if (tx_err !== 1'b0) begin failures++; $display("FAIL to_err_early: got %b want 0", tx_err); end
    @(negedge clk);
    checks += 2;
    if (tx_err !== 1'b1)        begin failures++; $display("FAIL to_err_set: got %b want 1", tx_err); end
    if (uart_tx_start !== 1'b0) begin failures++; $display("FAIL to_start_low: got %b want 0", uart_tx_start); end
    @(negedge clk);
    checks += 2;
    if (uart_tx_start !== 1'b1) begin failures++; $display("FAIL to_start2: got %b want 1", uart_tx_start); end
    if (uart_tx_data !== 8'h82) begin failures++; $display("FAIL to_data2: got %h want 82", uart_tx_data); end
    repeat (3) @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_err !== 1'b1) begin failures++; $display("FAIL to_set_wins: got %b want 1", tx_err); end
    @(negedge clk); overflow_clr = 1'b0;
    checks++;
    if (tx_err !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", tx_err); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_concurrent_wrap();
    test_flush();
    test_timeout();
    checks++;
    if (double_start) begin failures++; $display("FAIL start_pulse_width: got multi-cycle pulse want single"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
